// File: rtl/mips_cpu_pkg.sv
// Shared types, default addresses and helpers for the MIPS CPU PC path.
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDRESS_DEFAULT = 32'h00000000;

  function automatic logic [31:0] sext16to32(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/mips_cpu_branch_target.sv
// Combinational control-transfer target computation for the PC sequencer.
module mips_cpu_branch_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump_imm,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] seq_pc,
  output logic [31:0] target,
  output logic        take,
  output logic        misaligned
);

  logic [31:0] branch_target;
  logic [31:0] jump_target;

  // Candidate targets, all relative to the delay-slot address, then priority pick.
  always_comb begin
    seq_pc        = pc + 32'd4;
    branch_target = seq_pc + (sext16to32(branch_offset) << 2);
    jump_target   = {seq_pc[31:28], jump_index, 2'b00};
    take          = jump_reg | jump_imm | branch_taken;
    misaligned    = jump_reg & (reg_target[1:0] != 2'b00);
    target        = branch_target;
    if (jump_reg) begin
      target = reg_target;
    end else if (jump_imm) begin
      target = jump_target;
    end
  end

endmodule

// File: rtl/mips_cpu_pc_sequencer.sv
// Program counter sequencer: branches, jumps, single delay slot and halt detection.
module mips_cpu_pc_sequencer
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] HALT_ADDRESS = HALT_ADDRESS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        branch_taken,
  input  logic [15:0] branch_offset,
  input  logic        jump_imm,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_address,
  output logic        in_delay_slot,
  output logic        active,
  output logic        address_error
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        err_q, err_d;

  logic [31:0] seq_pc;
  logic [31:0] target;
  logic        take;
  logic        misaligned;

  mips_cpu_branch_target u_target (
    .pc            (pc_q),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_imm      (jump_imm),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .seq_pc        (seq_pc),
    .target        (target),
    .take          (take),
    .misaligned    (misaligned)
  );

  // State, PC, pending target and sticky error register; clk_enable gates every update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
      err_q     <= 1'b0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic; control inputs are only honoured in RUN.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
    err_d     = err_q;
    case (state_q)
      RUN: begin
        pc_d = seq_pc;
        if (take) begin
          pending_d = target;
          state_d   = DELAY;
          if (misaligned) begin
            err_d = 1'b1;
          end
        end
      end
      DELAY: begin
        if ((pending_q == HALT_ADDRESS) || err_q) begin
          pc_d    = HALT_ADDRESS;
          state_d = HALTED;
        end else begin
          pc_d    = pending_q;
          state_d = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // Outputs derive from registered state, so they move only on edges or reset.
  always_comb begin
    instr_address = pc_q;
    link_address  = pc_q + 32'd8;
    in_delay_slot = (state_q == DELAY);
    active        = (state_q != HALTED);
    address_error = err_q;
  end

endmodule

// File: doc/mips_cpu_pc_sequencer.md
Name: mips_cpu_pc_sequencer

Overview:
Owns the program counter of mips_cpu_harvard and drives instr_address. It resolves conditional branches, J/JAL and JR/JALR, and applies MIPS single-delay-slot semantics. It detects program termination (a completed jump to address 0), deasserts active, and freezes fetch until reset.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
HALT_ADDRESS, 32'h00000000, jump target that ends execution.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
clk_enable  input  1  advance gate; 0 holds all state.
branch_taken  input  1  conditional branch in current instruction resolved taken.
branch_offset  input  16  branch immediate (word offset, signed).
jump_imm  input  1  current instruction is J/JAL.
jump_index  input  26  J-type index field.
jump_reg  input  1  current instruction is JR/JALR.
reg_target  input  32  rs value for JR/JALR.
instr_address  output  32  current fetch PC.
link_address  output  32  instr_address+8, for JAL/JALR/BGEZAL writeback.
in_delay_slot  output  1  current instruction is a delay slot.
active  output  1  CPU running.
address_error  output  1  sticky: JR target not word-aligned.

Behaviour:
- Reset (async, any time, including mid-DELAY): instr_address=RESET_VECTOR, state=RUN, pending=0, active=1, in_delay_slot=0, address_error=0.
- States: RUN, DELAY, HALTED. Transitions only on rising clk with clk_enable=1. With clk_enable=0, everything is held, including the pending target.
- RUN:
  - Priority: jump_reg > jump_imm > branch_taken.
  - Branch target = instr_address+4 + (sext(branch_offset)<<2).
  - J target = {(instr_address+4)[31:28], jump_index, 2'b00}.
  - JR target = reg_target.
  - If any control request is set: pending<=target; instr_address<=instr_address+4; go to DELAY.
  - Otherwise instr_address<=instr_address+4.
  - JR with reg_target[1:0]!=0 sets address_error<=1. The target is still latched.
- DELAY:
  - Control inputs are ignored (a branch inside a delay slot is not supported).
  - If pending==HALT_ADDRESS or address_error=1: instr_address<=HALT_ADDRESS, active<=0, go to HALTED.
  - Otherwise instr_address<=pending; go to RUN.
- HALTED: all outputs held. active=0 until reset; inputs ignored.
- in_delay_slot = (state==DELAY), registered with state.
- link_address is combinational: instr_address+8.
- All adds are 32-bit modulo 2^32; 32'hFFFFFFFC+4 wraps to 0 without error.
- A sequential fall-through to HALT_ADDRESS does not halt; only a taken control transfer does.
- Outputs update only on clock edges, except on reset assertion.

Decomposition:
- mips_cpu_pkg holds:
  - pc_state_t enum {RUN, DELAY, HALTED}
  - RESET_VECTOR_DEFAULT and HALT_ADDRESS_DEFAULT constants
  - function sext16to32
- One combinational sub-module, mips_cpu_branch_target, computes the three candidate targets and the priority-selected target. The sequencer keeps the state register, PC register, pending register and sticky flags.

Test Plan:
- Reset: assert reset for 1 ns mid-DELAY with pending=BFC00020 -> instr_address=BFC00000 immediately, active=1, in_delay_slot=0. After release, 3 enabled clocks -> BFC00004, BFC00008, BFC0000C.
- Forward branch: branch_taken=1, offset=16'h0003 at BFC00008 -> next BFC0000C with in_delay_slot=1, then BFC00018; link_address at BFC00008 = BFC00010.
- Backward branch and J: offset=16'hFFFF at BFC00010 -> BFC00014 then BFC00010. jump_imm=1, index=26'h3F00008 at BFC00000 -> BFC00004 then BFC00020.
- Priority and delay-slot masking:
  - jump_reg=1 (reg_target=BFC00040) with branch_taken=1 in the same cycle -> target BFC00040.
  - jump_imm=1 asserted during DELAY -> ignored.
- Halt: jump_reg=1, reg_target=0 at BFC0002C -> BFC00030 (active=1), then 00000000 with active=0. It holds for 10 more clocks despite branch_taken/jump_reg toggling.
- Stall and error:
  - clk_enable=0 for 2 clocks during DELAY -> instr_address and in_delay_slot unchanged, then resumes to pending.
  - reg_target=BFC00042 -> address_error=1, halt after the delay slot.
